// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide issue logic.
//   md_state_t   : controller state encoding
//   DIV_WIDTH    : default operand/result width
//   DIV_TIMEOUT  : default watchdog length in WAIT cycles
//   DIV0_QUOT    : quotient written on divide by zero (remainder is the raw dividend)
//   TMO_RESULT   : quotient/remainder written when the watchdog aborts
package md_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_TIMEOUT = 48;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    FIX,
    WB
  } md_state_t;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOT  = '1;
  localparam logic [DIV_WIDTH-1:0] TMO_RESULT = '0;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Bus between the divide issue controller and the unsigned iterative divider core.
//   core_start     : one-cycle launch pulse (controller -> core)
//   core_dividend  : unsigned dividend, stable from launch until finish
//   core_divisor   : unsigned divisor, stable from launch until finish
//   core_q/core_r  : unsigned quotient/remainder (core -> controller)
//   core_finish    : results valid this cycle (core -> controller)
// Modports: master = controller side, slave = core side.
interface div_issue_ctrl_if
  import md_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             core_start;
  logic [WIDTH-1:0] core_dividend;
  logic [WIDTH-1:0] core_divisor;
  logic [WIDTH-1:0] core_q;
  logic [WIDTH-1:0] core_r;
  logic             core_finish;

  modport master (
    output core_start, core_dividend, core_divisor,
    input  core_q, core_r, core_finish
  );

  modport slave (
    input  core_start, core_dividend, core_divisor,
    output core_q, core_r, core_finish
  );

endinterface

// File: rtl/sign_mag_conv.sv
// Conditional two's-complement negate. Used both to take the magnitude of a
// signed operand (negate when its sign is set) and to restore the sign of a
// result. The most negative value maps to itself, which is what makes the
// 0x80000000 / -1 overflow case come out as 0x80000000 with no special path.
//   value  : input word
//   negate : 1 = output -value, 0 = output value
//   result : converted word (combinational)
module sign_mag_conv
  import md_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for DIV/DIVU in front of an unsigned iterative
// divider core. Accepts an op, stalls the pipeline, launches the core on the
// operand magnitudes, sign-corrects the results and writes LO (quotient) and
// HI (remainder) for one cycle. A watchdog aborts with zero results if the
// core never finishes.
// Optional feature macro: DIV_ZERO_TRAP_EN
//   defined   : divide by zero pulses div_zero_exc in WB, HI/LO not written
//   undefined : divide by zero writes lo=all-ones, hi=dividend; div_zero_exc = 0
// Ports:
//   clock, reset        : clock, asynchronous active-high reset
//   ex_valid            : EX holds a valid instruction
//   ex_op_div/divu      : signed / unsigned divide
//   ex_rs, ex_rt        : dividend, divisor
//   cpu_stall           : global stall, blocks acceptance
//   md_stall            : stall request (combinational)
//   hi_we/lo_we         : HI/LO write strobes
//   hi_wdata/lo_wdata   : remainder / quotient
//   div_zero_exc        : divide-by-zero trap pulse
//   core                : divider core bus (master side)
module div_issue_ctrl
  import md_pkg::*;
#(
  parameter int WIDTH       = DIV_WIDTH,
  parameter int TIMEOUT_CYC = DIV_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_op_div,
  input  logic             ex_op_divu,
  input  logic [WIDTH-1:0] ex_rs,
  input  logic [WIDTH-1:0] ex_rt,
  input  logic             cpu_stall,
  output logic             md_stall,
  output logic             hi_we,
  output logic             lo_we,
  output logic [WIDTH-1:0] hi_wdata,
  output logic [WIDTH-1:0] lo_wdata,
  output logic             div_zero_exc,
  div_issue_ctrl_if.master core
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  md_state_t        state_reg, state_next;
  logic             sa_reg, sa_next;
  logic             sb_reg, sb_next;
  logic [WIDTH-1:0] a_mag_reg, a_mag_next;
  logic [WIDTH-1:0] b_mag_reg, b_mag_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             start_reg, start_next;
  logic             we_reg, we_next;
  logic [WIDTH-1:0] hi_wdata_reg, hi_wdata_next;
  logic [WIDTH-1:0] lo_wdata_reg, lo_wdata_next;

  // Converters: [0]=rs magnitude, [1]=rt magnitude, [2]=signed quotient, [3]=signed remainder
  logic [WIDTH-1:0] conv_in  [4];
  logic             conv_neg [4];
  logic [WIDTH-1:0] conv_out [4];

  assign conv_in[0]  = ex_rs;
  assign conv_neg[0] = ex_rs[WIDTH-1] & ex_op_div;
  assign conv_in[1]  = ex_rt;
  assign conv_neg[1] = ex_rt[WIDTH-1] & ex_op_div;
  // Quotient is negative when the operand signs differ; remainder follows the dividend.
  assign conv_in[2]  = q_reg;
  assign conv_neg[2] = sa_reg ^ sb_reg;
  assign conv_in[3]  = r_reg;
  assign conv_neg[3] = sa_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_conv
      sign_mag_conv #(.WIDTH(WIDTH)) u_conv (
        .value  (conv_in[gi]),
        .negate (conv_neg[gi]),
        .result (conv_out[gi])
      );
    end
  endgenerate

  logic accept;
  logic div_zero;
  assign accept   = ex_valid & (ex_op_div | ex_op_divu) & ~cpu_stall;
  assign div_zero = (ex_rt == '0);

`ifdef DIV_ZERO_TRAP_EN
  logic exc_reg, exc_next;
`endif

  always_comb begin
    state_next    = state_reg;
    sa_next       = sa_reg;
    sb_next       = sb_reg;
    a_mag_next    = a_mag_reg;
    b_mag_next    = b_mag_reg;
    q_next        = q_reg;
    r_next        = r_reg;
    cnt_next      = cnt_reg;
    start_next    = 1'b0;
    we_next       = 1'b0;
    hi_wdata_next = hi_wdata_reg;
    lo_wdata_next = lo_wdata_reg;
`ifdef DIV_ZERO_TRAP_EN
    exc_next      = 1'b0;
`endif
    md_stall      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          md_stall   = 1'b1;
          sa_next    = conv_neg[0];
          sb_next    = conv_neg[1];
          a_mag_next = conv_out[0];
          b_mag_next = conv_out[1];
          if (div_zero) begin
            // The core is bypassed; the WB strobes are prepared here.
            state_next = WB;
`ifdef DIV_ZERO_TRAP_EN
            exc_next      = 1'b1;
`else
            we_next       = 1'b1;
            lo_wdata_next = WIDTH'(DIV0_QUOT);
            hi_wdata_next = ex_rs;
`endif
          end else begin
            state_next = LAUNCH;
            start_next = 1'b1;
          end
        end
      end
      LAUNCH: begin
        md_stall   = 1'b1;
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        md_stall = 1'b1;
        cnt_next = cnt_reg + CNT_W'(1);
        // A finish on the last allowed cycle still wins over the watchdog.
        if (core.core_finish) begin
          q_next     = core.core_q;
          r_next     = core.core_r;
          state_next = FIX;
        end else if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
          q_next        = WIDTH'(TMO_RESULT);
          r_next        = WIDTH'(TMO_RESULT);
          we_next       = 1'b1;
          lo_wdata_next = WIDTH'(TMO_RESULT);
          hi_wdata_next = WIDTH'(TMO_RESULT);
          state_next    = WB;
        end
      end
      FIX: begin
        md_stall      = 1'b1;
        we_next       = 1'b1;
        lo_wdata_next = conv_out[2];
        hi_wdata_next = conv_out[3];
        state_next    = WB;
      end
      WB: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      sa_reg       <= 1'b0;
      sb_reg       <= 1'b0;
      a_mag_reg    <= '0;
      b_mag_reg    <= '0;
      q_reg        <= '0;
      r_reg        <= '0;
      cnt_reg      <= '0;
      start_reg    <= 1'b0;
      we_reg       <= 1'b0;
      hi_wdata_reg <= '0;
      lo_wdata_reg <= '0;
`ifdef DIV_ZERO_TRAP_EN
      exc_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      sa_reg       <= sa_next;
      sb_reg       <= sb_next;
      a_mag_reg    <= a_mag_next;
      b_mag_reg    <= b_mag_next;
      q_reg        <= q_next;
      r_reg        <= r_next;
      cnt_reg      <= cnt_next;
      start_reg    <= start_next;
      we_reg       <= we_next;
      hi_wdata_reg <= hi_wdata_next;
      lo_wdata_reg <= lo_wdata_next;
`ifdef DIV_ZERO_TRAP_EN
      exc_reg      <= exc_next;
`endif
    end
  end

  assign core.core_start    = start_reg;
  assign core.core_dividend = a_mag_reg;
  assign core.core_divisor  = b_mag_reg;
  assign hi_we              = we_reg;
  assign lo_we              = we_reg;
  assign hi_wdata           = hi_wdata_reg;
  assign lo_wdata           = lo_wdata_reg;
`ifdef DIV_ZERO_TRAP_EN
  assign div_zero_exc       = exc_reg;
`else
  assign div_zero_exc       = 1'b0;
`endif

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: directed and random divides, a behavioural
// divider core, and a scoreboard monitor on the HI/LO write port.
module tb_div_issue_ctrl;
  import md_pkg::*;

  localparam int W   = 32;
  localparam int TMO = 48;

  logic         clock = 1'b0;
  logic         reset;
  logic         ex_valid, ex_op_div, ex_op_divu, cpu_stall;
  logic [W-1:0] ex_rs, ex_rt;
  logic         md_stall, hi_we, lo_we, div_zero_exc;
  logic [W-1:0] hi_wdata, lo_wdata;

  always #5 clock = ~clock;

  div_issue_ctrl_if #(.WIDTH(W)) core_bus ();

  div_issue_ctrl #(.WIDTH(W), .TIMEOUT_CYC(TMO)) dut (
    .clock        (clock),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .ex_op_div    (ex_op_div),
    .ex_op_divu   (ex_op_divu),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .cpu_stall    (cpu_stall),
    .md_stall     (md_stall),
    .hi_we        (hi_we),
    .lo_we        (lo_we),
    .hi_wdata     (hi_wdata),
    .lo_wdata     (lo_wdata),
    .div_zero_exc (div_zero_exc),
    .core         (core_bus)
  );

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    bit          exc;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } core_exp_t;

  exp_t      exp_q[$];
  core_exp_t core_exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cnt = 0;
  int core_n = 1;
  bit core_withhold = 1'b0;
  bit spurious_req = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference divide: signed ops truncate toward zero, remainder takes the dividend's sign.
  function automatic void ref_div(input bit sgn, input logic [31:0] rs, input logic [31:0] rt,
                                  output logic [31:0] lo, output logic [31:0] hi);
    int a, b;
    if (rt == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = rs;
    end else if (!sgn) begin
      lo = rs / rt;
      hi = rs % rt;
    end else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
      lo = 32'h8000_0000;
      hi = 32'd0;
    end else begin
      a  = int'(rs);
      b  = int'(rt);
      lo = 32'(a / b);
      hi = 32'(a % b);
    end
  endfunction

  function automatic logic [31:0] mag(input bit sgn, input logic [31:0] x);
    longint v;
    v = longint'(int'(x));
    if (sgn && v < 0) return 32'(-v);
    return x;
  endfunction

  // Behavioural divider core: finishes core_n cycles after start, unless withheld.
  initial begin
    int rem;
    logic [31:0] cur_a, cur_b;
    core_exp_t c;
    rem = -1;
    cur_a = '0;
    cur_b = '0;
    core_bus.core_finish = 1'b0;
    core_bus.core_q = '0;
    core_bus.core_r = '0;
    forever begin
      @(negedge clock);
      core_bus.core_finish = 1'b0;
      if (reset) begin
        rem = -1;
      end else begin
        if (rem > 0) rem--;
        if (rem == 0) begin
          chk("dividend_stable", core_bus.core_dividend, cur_a);
          chk("divisor_stable", core_bus.core_divisor, cur_b);
          core_bus.core_finish = 1'b1;
          core_bus.core_q = cur_a / cur_b;
          core_bus.core_r = cur_a % cur_b;
          rem = -1;
        end
        if (core_bus.core_start) begin
          start_cnt++;
          cur_a = core_bus.core_dividend;
          cur_b = core_bus.core_divisor;
          if (core_exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_core_start: dividend=%h divisor=%h", cur_a, cur_b);
          end else begin
            c = core_exp_q.pop_front();
            chk("core_dividend", cur_a, c.a);
            chk("core_divisor", cur_b, c.b);
          end
          if (!core_withhold) rem = core_n;
        end
        if (spurious_req) begin
          core_bus.core_finish = 1'b1;
          core_bus.core_q = 32'hDEAD_BEEF;
          core_bus.core_r = 32'h1234_5678;
          spurious_req = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor on the HI/LO write port.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && (lo_we || hi_we || div_zero_exc)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: lo_we=%b hi_we=%b exc=%b lo=%h hi=%h",
                   lo_we, hi_we, div_zero_exc, lo_wdata, hi_wdata);
        end else begin
          e = exp_q.pop_front();
          $display("wb cyc=%0d lo=%h hi=%h exc=%b (expect lo=%h hi=%h exc=%b)",
                   cyc, lo_wdata, hi_wdata, div_zero_exc, e.lo, e.hi, e.exc);
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("md_stall_in_wb", 32'(md_stall), 32'd0);
          chk("div_zero_exc", 32'(div_zero_exc), 32'(e.exc));
          if (e.exc) begin
            chk("we_on_trap", 32'({lo_we, hi_we}), 32'd0);
          end else begin
            chk("we", 32'({lo_we, hi_we}), 32'd3);
            chk("lo_wdata", lo_wdata, e.lo);
            chk("hi_wdata", hi_wdata, e.hi);
          end
        end
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clock);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d writes still pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_op(input bit sgn, input logic [31:0] rs, input logic [31:0] rt,
                        input int n, input bit withhold, input bit stall_first);
    exp_t e;
    core_exp_t c;
    logic [31:0] elo, ehi;
    @(posedge clock);
    #1;
    ex_op_div  = sgn;
    ex_op_divu = !sgn;
    ex_rs      = rs;
    ex_rt      = rt;
    if (stall_first) begin
      cpu_stall = 1'b1;
      ex_valid  = 1'b1;
      @(negedge clock);
      chk("stall_blocks_accept", 32'(md_stall), 32'd0);
      @(posedge clock);
      #1;
      cpu_stall = 1'b0;
    end
    ex_valid      = 1'b1;
    core_n        = n;
    core_withhold = withhold;
    @(negedge clock);
    chk("accept_stall", 32'(md_stall), 32'd1);
    ref_div(sgn, rs, rt, elo, ehi);
    e.lo  = elo;
    e.hi  = ehi;
    e.exc = 1'b0;
    e.acc = cyc;
    if (rt == 32'd0) begin
`ifdef DIV_ZERO_TRAP_EN
      e.exc = 1'b1;
`endif
      e.lat = 1;
    end else begin
      c.a = mag(sgn, rs);
      c.b = mag(sgn, rt);
      core_exp_q.push_back(c);
      if (withhold) begin
        e.lo  = 32'd0;
        e.hi  = 32'd0;
        e.lat = TMO + 2;
      end else begin
        e.lat = n + 3;
      end
    end
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (rt != 32'd0) begin
      // A second request during LAUNCH must be ignored.
      ex_rs = $urandom;
      ex_rt = $urandom | 32'd1;
      @(posedge clock);
      #1;
    end
    ex_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    bit sgn;
    logic [31:0] rs, rt;
    reset      = 1'b1;
    ex_valid   = 1'b0;
    ex_op_div  = 1'b0;
    ex_op_divu = 1'b0;
    ex_rs      = '0;
    ex_rt      = '0;
    cpu_stall  = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_md_stall", 32'(md_stall), 32'd0);
    chk("rst_hi_we", 32'(hi_we), 32'd0);
    chk("rst_lo_we", 32'(lo_we), 32'd0);
    chk("rst_hi_wdata", hi_wdata, 32'd0);
    chk("rst_lo_wdata", lo_wdata, 32'd0);
    chk("rst_core_start", 32'(core_bus.core_start), 32'd0);
    chk("rst_core_dividend", core_bus.core_dividend, 32'd0);
    chk("rst_core_divisor", core_bus.core_divisor, 32'd0);
    chk("rst_div_zero_exc", 32'(div_zero_exc), 32'd0);
    reset = 1'b0;

    run_op(1'b0, 32'd100, 32'd7, 4, 1'b0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 3, 1'b0, 1'b1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5, 1'b0, 1'b0);
    s0 = start_cnt;
    run_op(1'b0, 32'd5, 32'd0, 1, 1'b0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF0, 32'd0, 1, 1'b0, 1'b0);
    chk("no_core_start_div0", 32'(start_cnt), 32'(s0));
    run_op(1'b0, 32'd1000, 32'd10, 1, 1'b1, 1'b0);
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, TMO, 1'b0, 1'b0);

    // Spurious finish while idle must not produce a write.
    @(posedge clock);
    #1;
    spurious_req = 1'b1;
    repeat (4) @(negedge clock);
    chk("spurious_md_stall", 32'(md_stall), 32'd0);
    chk("spurious_lo_we", 32'(lo_we), 32'd0);

    // Reset in the middle of WAIT aborts with no write.
    @(posedge clock);
    #1;
    ex_valid = 1'b1; ex_op_div = 1'b0; ex_op_divu = 1'b1;
    ex_rs = 32'd100; ex_rt = 32'd7;
    core_n = 30; core_withhold = 1'b0;
    @(negedge clock);
    chk("mid_accept_stall", 32'(md_stall), 32'd1);
    begin
      core_exp_t c;
      c.a = 32'd100;
      c.b = 32'd7;
      core_exp_q.push_back(c);
    end
    @(posedge clock);
    #1;
    ex_valid = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_md_stall", 32'(md_stall), 32'd0);
    chk("midrst_we", 32'({lo_we, hi_we}), 32'd0);
    chk("midrst_core_start", 32'(core_bus.core_start), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (60) @(negedge clock);
    run_op(1'b0, 32'd9, 32'd3, 2, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      sgn = 1'($urandom_range(0, 1));
      rs  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      case ($urandom_range(0, 7))
        0:       rt = 32'd0;
        1, 2:    rt = 32'($urandom_range(1, 20));
        3:       rt = 32'(-$urandom_range(1, 20));
        default: rt = $urandom;
      endcase
      if (sgn && $urandom_range(0, 1) == 1 && rs[31] == 1'b0) rs = 32'(-int'(rs));
      run_op(sgn, rs, rt, $urandom_range(1, 12), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 3) == 0));
    end

    wait_drain();
    repeat (5) @(negedge clock);
    chk("core_queue_empty", 32'(core_exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
